// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit memory port for an RV32 core.
//
// Takes one byte-addressed load/store request at a time. It turns the request
// into one or two word-wide memory accesses with byte-lane masks, and returns
// the aligned, extended load result (or a store acknowledge) as a one-cycle
// response. An access that crosses a word boundary is split into two accesses.
//
// Ports:
//   i_clk, i_reset         clock; synchronous active-low reset
//   i_req_valid/o_req_ready request handshake (ready only while idle)
//   i_req_wren, i_req_funct3, i_req_addr, i_req_wdata   request fields
//   o_rsp_valid, o_rsp_rdata, o_rsp_misaligned, o_rsp_err  one-cycle response
//   o_mem_addr (word index), o_mem_wdata, o_mem_bmask, o_mem_wren  memory port
//   i_mem_rdata            combinational read data for o_mem_addr
//
// All outputs are registered. Each one is loaded from the value it must carry
// in the state being entered, so every output changes in step with the state.
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wren,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_misaligned,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Funct3 codes 011/110/111 never exist; the unsigned codes exist only for loads.
  function automatic logic f_illegal(input logic wren, input logic [2:0] funct3);
    logic ill;
    case (funct3)
      3'b000, 3'b001, 3'b010: ill = 1'b0;
      3'b100, 3'b101:         ill = wren;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Truncate the already right-aligned load data to the access size and extend it.
  function automatic logic [31:0] f_load_ext(input logic [2:0] funct3, input logic [31:0] raw);
    logic [31:0] res;
    case (funct3)
      3'b000:  res = {{24{raw[7]}}, raw[7:0]};
      3'b001:  res = {{16{raw[15]}}, raw[15:0]};
      3'b010:  res = raw;
      3'b100:  res = {24'h000000, raw[7:0]};
      3'b101:  res = {16'h0000, raw[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_req_ready;
  logic        r_wren;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_r0;
  logic [31:0] r_r1;

  logic              w_accept;
  logic              w_wren;
  logic [2:0]        w_funct3;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic              w_illegal;
  logic              w_store;
  logic [3:0]        w_smask;
  logic [7:0]        w_mask8;
  logic              w_split;
  logic [63:0]       w_data64;
  logic [ADDR_W-1:0] w_addr0;
  logic [31:0]       w_r0_nxt;
  logic [31:0]       w_r1_nxt;
  logic [31:0]       w_load;

  assign o_req_ready = r_req_ready;

  // Request decode, lane/data alignment, load assembly and next-state logic.
  always_comb begin
    w_accept = i_req_valid & r_req_ready;
    // On the accept edge the registers load only at that edge, so decode the live inputs.
    if (w_accept) begin
      w_wren   = i_req_wren;
      w_funct3 = i_req_funct3;
      w_addr   = i_req_addr;
      w_wdata  = i_req_wdata;
    end else begin
      w_wren   = r_wren;
      w_funct3 = r_funct3;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
    end

    w_illegal = f_illegal(w_wren, w_funct3);
    w_store   = w_wren & ~w_illegal;

    // An illegal request has an empty size mask, so it can never split or write.
    if (w_illegal) begin
      w_smask = 4'b0000;
    end else begin
      case (w_funct3[1:0])
        2'b00:   w_smask = 4'b0001;
        2'b01:   w_smask = 4'b0011;
        2'b10:   w_smask = 4'b1111;
        default: w_smask = 4'b0000;
      endcase
    end

    w_mask8  = {4'b0000, w_smask} << w_addr[1:0];
    w_split  = |w_mask8[7:4];
    w_data64 = {32'h0000_0000, w_wdata} << {w_addr[1:0], 3'b000};
    w_addr0  = ADDR_W'(w_addr[31:2]);

    // Read data as it will stand once the current access cycle ends.
    if (r_state == ST_ACC0) begin
      w_r0_nxt = i_mem_rdata;
    end else begin
      w_r0_nxt = r_r0;
    end
    if (r_state == ST_ACC1) begin
      w_r1_nxt = i_mem_rdata;
    end else begin
      w_r1_nxt = r_r1;
    end
    w_load = f_load_ext(w_funct3, 32'({w_r1_nxt, w_r0_nxt} >> {w_addr[1:0], 3'b000}));

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ACC0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACC0: begin
        if (w_split) begin
          w_state_nxt = ST_ACC1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_ACC1: w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the request fields on the accept edge only.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wren   <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_wren   <= i_req_wren;
      r_funct3 <= i_req_funct3;
      r_addr   <= i_req_addr;
      r_wdata  <= i_req_wdata;
    end
  end

  // Hold the read words of each access; R1 is cleared on accept so unsplit loads see zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_r0 <= 32'h0000_0000;
      r_r1 <= 32'h0000_0000;
    end else if (w_accept) begin
      r_r0 <= 32'h0000_0000;
      r_r1 <= 32'h0000_0000;
    end else begin
      r_r0 <= w_r0_nxt;
      r_r1 <= w_r1_nxt;
    end
  end

  // Registered outputs, loaded with the values belonging to the state being entered.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_req_ready      <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_wdata      <= 32'h0000_0000;
      o_mem_bmask      <= 4'b0000;
      o_mem_wren       <= 1'b0;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= 32'h0000_0000;
      o_rsp_misaligned <= 1'b0;
      o_rsp_err        <= 1'b0;
    end else begin
      r_req_ready      <= (w_state_nxt == ST_IDLE);
      o_mem_addr       <= '0;
      o_mem_wdata      <= 32'h0000_0000;
      o_mem_bmask      <= 4'b0000;
      o_mem_wren       <= 1'b0;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= 32'h0000_0000;
      o_rsp_misaligned <= 1'b0;
      o_rsp_err        <= 1'b0;
      case (w_state_nxt)
        ST_ACC0: begin
          o_mem_addr  <= w_addr0;
          o_mem_wdata <= w_data64[31:0];
          o_mem_bmask <= w_store ? w_mask8[3:0] : 4'b0000;
          o_mem_wren  <= w_store;
        end
        ST_ACC1: begin
          o_mem_addr  <= w_addr0 + ADDR_W'(1'b1);
          o_mem_wdata <= w_data64[63:32];
          o_mem_bmask <= w_store ? w_mask8[7:4] : 4'b0000;
          o_mem_wren  <= w_store;
        end
        ST_RESP: begin
          o_rsp_valid      <= 1'b1;
          o_rsp_rdata      <= (w_wren | w_illegal) ? 32'h0000_0000 : w_load;
          o_rsp_misaligned <= w_split;
          o_rsp_err        <= w_illegal;
        end
        default: begin
          o_mem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: directed requests against a small byte-masked
// memory model. Expected responses go into a scoreboard queue when a request
// is accepted; a monitor pops and compares on every o_rsp_valid cycle.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wren;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_misaligned;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_port #(.ADDR_W(32)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_wren(i_req_wren), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_misaligned(o_rsp_misaligned), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren),
    .i_mem_rdata(i_mem_rdata)
  );

  // Memory model: 16 words, combinational read, byte-masked write, preload port.
  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_val = 32'h0;

  assign i_mem_rdata = mem[o_mem_addr[3:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (o_mem_wren) begin
      for (int b = 0; b < 4; b++) begin
        if (o_mem_bmask[b]) mem[o_mem_addr[3:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int last_n = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Response monitor: every o_rsp_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (o_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {31'h0, o_rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e.rdata);
        chk("rsp_misaligned", {31'h0, o_rsp_misaligned}, {31'h0, e.mis});
        chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, e.err});
        chk("rsp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic mem_set(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Present a request until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_mis, input logic exp_err, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_wren = wren; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wdata;
    while (o_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (o_req_ready !== 1'b1) chk("accept_timeout", {31'h0, o_req_ready}, 32'h1);
    last_n = cyc;
    @(posedge clk); #1;
    // Scramble the request inputs: they must be ignored after acceptance.
    i_req_valid = 1'b0; i_req_wren = ~wren; i_req_funct3 = 3'b111;
    i_req_addr = $urandom; i_req_wdata = $urandom;
    if (push) sb.push_back('{rdata: exp_rd, mis: exp_mis, err: exp_err,
                             cyc: last_n + (exp_mis ? 3 : 2)});
  endtask

  task automatic chk_port(input string nm, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input logic wren, input bit cmp_wdata);
    chk({nm, "_addr"}, o_mem_addr, addr);
    chk({nm, "_bmask"}, {28'h0, o_mem_bmask}, {28'h0, mask});
    chk({nm, "_wren"}, {31'h0, o_mem_wren}, {31'h0, wren});
    if (cmp_wdata) chk({nm, "_wdata"}, o_mem_wdata, wdata);
  endtask

  initial begin
    int prev_n;
    logic [31:0] saved;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_n;
    logic [31:0] saved;
    i_reset = 1'b0; i_req_valid = 1'b0; i_req_wren = 1'b0;
    i_req_funct3 = 3'b000; i_req_addr = 32'h0; i_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, o_req_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("reset_mem_wren", {31'h0, o_mem_wren}, 32'h0);
    i_reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, o_req_ready}, 32'h1);

    mem_set(4'd0, 32'h1111_1111);
    mem_set(4'd1, 32'h80FF_0000);
    mem_set(4'd2, 32'hDEAD_BEEF);
    mem_set(4'd3, 32'h4444_4444);
    mem_set(4'd5, 32'h8001_1234);
    mem_set(4'd6, 32'h0000_00C5);

    // LW aligned
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_port("lw_acc0", 32'd2, 4'b0000, 32'h0, 1'b0, 1'b0);

    // LB then LBU back to back at 0x7
    issue(1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1);
    prev_n = last_n;
    issue(1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
    chk("throughput_unsplit", last_n - prev_n, 32'd3);

    // SH split across words 0 and 1
    issue(1'b1, 3'b001, 32'h3, 32'h0000_ABCD, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk_port("sh_acc0", 32'd0, 4'b1000, 32'hCD00_0000, 1'b1, 1'b1);
    @(negedge clk);
    chk_port("sh_acc1", 32'd1, 4'b0001, 32'h0000_00AB, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("sh_mem0", mem[0], 32'hCD11_1111);
    chk("sh_mem1", mem[1], 32'h80FF_00AB);

    // LW split at 0x6
    mem_set(4'd1, 32'h3322_1100);
    mem_set(4'd2, 32'h7766_5544);
    issue(1'b0, 3'b010, 32'h6, 32'h0, 32'h5544_3322, 1'b1, 1'b0, 1'b1);
    prev_n = last_n;
    issue(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1);
    chk("throughput_split", last_n - prev_n, 32'd4);

    // LHU split at 0x17: byte 0x80 from mem[5], byte 0xC5 from mem[6]
    issue(1'b0, 3'b101, 32'h17, 32'h0, 32'h0000_C580, 1'b1, 1'b0, 1'b1);

    // SB at 0xD
    issue(1'b1, 3'b000, 32'hD, 32'h0000_00EE, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_port("sb_acc0", 32'd3, 4'b0010, 32'h0000_EE00, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("sb_mem3", mem[3], 32'h4444_EE44);

    // Illegal: store funct3 011, store funct3 101, load funct3 110
    issue(1'b1, 3'b011, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_port("ill_sd_acc0", 32'd4, 4'b0000, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 3'b101, 32'h3, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_port("ill_shu_acc0", 32'd0, 4'b0000, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Reset during ACC0 of a split SW at 0x2: no ACC1 write, no response
    saved = mem[1];
    issue(1'b1, 3'b010, 32'h2, 32'hCAFE_F00D, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_in_reset", {31'h0, o_req_ready}, 32'h0);
    chk("abort_mem_wren", {31'h0, o_mem_wren}, 32'h0);
    i_reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", {31'h0, o_req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("abort_mem1_unchanged", mem[1], saved);

    // Recovery after the aborted request
    issue(1'b0, 3'b010, 32'h4, 32'h0, saved, 1'b0, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, which sets the width of the memory word-index address.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports i_req_valid (in, 1) and o_req_ready (out, 1): request handshake from the core.
REQ-005 SHALL have request inputs i_req_wren (1, 1=store), i_req_funct3 (3, RV32 load/store funct3), i_req_addr (32, byte address) and i_req_wdata (32, store data, right-aligned).
REQ-006 SHALL have response outputs o_rsp_valid (1), o_rsp_rdata (32), o_rsp_misaligned (1, access was split) and o_rsp_err (1, illegal funct3).
REQ-007 SHALL have memory-port outputs o_mem_addr (ADDR_W, word index), o_mem_wdata (32), o_mem_bmask (4) and o_mem_wren (1), plus input i_mem_rdata (32, combinational read of o_mem_addr).

Function
REQ-008 SHALL accept a request on the rising edge where i_req_valid=1 and o_req_ready=1, capturing all request inputs; request inputs are ignored at all other times.
REQ-009 SHALL implement states IDLE, ACC0, ACC1 and RESP; o_req_ready=1 only in IDLE.
REQ-010 SHALL follow these state transitions: IDLE to ACC0 on accept; ACC0 to ACC1 if split, otherwise to RESP; ACC1 to RESP; RESP to IDLE.
REQ-011 SHALL decode funct3 as follows: 000 byte signed (LB/SB); 001 half signed (LH/SH); 010 word (LW/SW); 100 byte unsigned (LBU); 101 half unsigned (LHU).
REQ-012 SHALL treat a store with funct3 100 or 101, and any funct3 of 011, 110 or 111, as illegal.
REQ-013 SHALL handle an illegal request as ACC0 then RESP with o_mem_wren=0 and o_mem_bmask=0 throughout, o_rsp_err=1 and o_rsp_rdata=0.
REQ-014 SHALL use size S of 1, 2 or 4 bytes and offset O=addr[1:0]; the access is split when O+S>4.
REQ-015 SHALL form the 8-bit lane mask M=((1<<S)-1)<<O and the 64-bit data D=wdata<<(8*O), both little-endian.
REQ-016 SHALL drive, in ACC0, o_mem_addr=addr[31:2] truncated/zero-extended to ADDR_W, o_mem_bmask=M[3:0] and o_mem_wdata=D[31:0].
REQ-017 SHALL drive, in ACC1, o_mem_addr=(ACC0 address+1) modulo 2^ADDR_W, o_mem_bmask=M[7:4] and o_mem_wdata=D[63:32].
REQ-018 SHALL assert o_mem_wren=1 in ACC0/ACC1 for legal stores only; loads drive o_mem_wren=0 and o_mem_bmask=0.
REQ-019 SHALL drive o_mem_addr, o_mem_wdata, o_mem_bmask and o_mem_wren to 0 in IDLE and RESP.
REQ-020 SHALL register i_mem_rdata at the end of ACC0 as R0 and at the end of ACC1 as R1 (R1=0 if not split).
REQ-021 SHALL form the load result as ({R1,R0}>>(8*O)) truncated to S bytes, then sign-extended for signed forms or zero-extended for unsigned forms.
REQ-022 SHALL assert o_rsp_valid for exactly the one cycle spent in RESP, with o_rsp_rdata, o_rsp_misaligned and o_rsp_err valid in that cycle and 0 otherwise.
REQ-023 SHALL return o_rsp_rdata=0 for a store.
REQ-024 SHALL have a latency, counted from an accept edge at cycle N, of o_rsp_valid at cycle N+2 when not split and N+3 when split.
REQ-025 SHALL sustain a throughput of one request per 3 cycles (4 if split); back-to-back acceptance is possible in the cycle after RESP.

Reset
REQ-026 SHALL, while i_reset=0 at a rising edge, set the state to IDLE and clear R0/R1, all captured request fields and all outputs to 0, including o_req_ready.
REQ-027 SHALL give reset priority over any other event; a reset mid-operation aborts it, with no further memory write and no response for the aborted request.
REQ-028 SHALL assert o_req_ready=1 in the first cycle after i_reset returns to 1.

Verification
REQ-029 SHALL be verified with: LW addr 0x8, mem[2]=0xDEADBEEF -> ACC0 o_mem_addr=2, o_mem_bmask=0, o_rsp_rdata=0xDEADBEEF at N+2, o_rsp_misaligned=0.
REQ-030 SHALL be verified with: LB addr 0x7, mem[1]=0x80FF0000 -> o_rsp_rdata=0xFFFFFF80; LBU at the same address -> o_rsp_rdata=0x00000080.
REQ-031 SHALL be verified with: SH addr 0x3, wdata 0x0000ABCD -> ACC0 o_mem_addr=0, o_mem_bmask=1000, o_mem_wdata=0xCD000000; ACC1 o_mem_addr=1, o_mem_bmask=0001, o_mem_wdata=0x000000AB; o_rsp_valid at N+3 with o_rsp_misaligned=1.
REQ-032 SHALL be verified with: LW addr 0x6, mem[1]=0x33221100, mem[2]=0x77665544 -> o_rsp_rdata=0x55443322, o_rsp_misaligned=1.
REQ-033 SHALL be verified with: store funct3=011 addr 0x10 -> o_mem_wren never asserted, o_rsp_err=1, o_rsp_rdata=0 at N+2.
REQ-034 SHALL be verified with: i_reset=0 during ACC0 of split SW addr 0x2 -> no ACC1 write (mem[1] unchanged), no o_rsp_valid, o_req_ready=1 in the first cycle after reset release.
